// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master = control unit, slave = datapath.
interface control_unit_if;
  logic [5:0] OP;
  logic [5:0] Funct;
  logic       ALU_overflow;
  logic       ALU_eq;
  logic       PcWrite;
  logic       Load_AB;
  logic       ALUOut_Load;
  logic       EPCwrite;
  logic       MemWrite;
  logic       MemRead;
  logic       IRWrite;
  logic       RegWrite;
  logic [2:0] ALUOp;
  logic [2:0] IorD;
  logic [1:0] ExCause;
  logic [2:0] WR_REG;
  logic [3:0] WD_REG;
  logic [2:0] ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] PcSource;
  logic       SingExCtrl;
  logic [1:0] LoadCtrl;
  logic [1:0] StoreCtrl;

  modport master (
    input  OP, Funct, ALU_overflow, ALU_eq,
    output PcWrite, Load_AB, ALUOut_Load, EPCwrite,
    output MemWrite, MemRead, IRWrite, RegWrite,
    output ALUOp, IorD, ExCause, WR_REG, WD_REG,
    output ALUSrcA, ALUSrcB, PcSource, SingExCtrl,
    output LoadCtrl, StoreCtrl
  );

  modport slave (
    output OP, Funct, ALU_overflow, ALU_eq,
    input  PcWrite, Load_AB, ALUOut_Load, EPCwrite,
    input  MemWrite, MemRead, IRWrite, RegWrite,
    input  ALUOp, IorD, ExCause, WR_REG, WD_REG,
    input  ALUSrcA, ALUSrcB, PcSource, SingExCtrl,
    input  LoadCtrl, StoreCtrl
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle control FSM for the MIPS-subset datapath.
// Outputs decode from the state plus IR fields and ALU flags.
module control_unit (
  input logic            clk,
  input logic            reset,
  control_unit_if.master cu
);
  typedef enum logic [4:0] {
    RESET_ST, FETCH, FETCH_W, DECODE,
    R_EX, R_WB, ADDI_EX, I_WB,
    ADDR, LW_RD, LW_W, LW_WB, SW_WR,
    BR, J, JAL, JR,
    EXC, EXC_W, EXC_LD
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] cause_q, cause_d;

  logic is_r, f_add, f_sub, f_and, f_jr;
  logic op_addi, op_lw, op_sw, op_beq, op_bne;
  logic op_j, op_jal, ovf_arith;

  assign is_r    = cu.OP == 6'h00;
  assign f_add   = cu.Funct == 6'h20;
  assign f_sub   = cu.Funct == 6'h22;
  assign f_and   = cu.Funct == 6'h24;
  assign f_jr    = cu.Funct == 6'h08;
  assign op_addi = cu.OP == 6'h08;
  assign op_lw   = cu.OP == 6'h23;
  assign op_sw   = cu.OP == 6'h2B;
  assign op_beq  = cu.OP == 6'h04;
  assign op_bne  = cu.OP == 6'h05;
  assign op_j    = cu.OP == 6'h02;
  assign op_jal  = cu.OP == 6'h03;
  // and never traps, whatever the flag says
  assign ovf_arith = (f_add | f_sub) & cu.ALU_overflow;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      RESET_ST: state_d = FETCH;
      FETCH:    state_d = FETCH_W;
      FETCH_W:  state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_r && (f_add || f_sub || f_and):
            state_d = R_EX;
          is_r && f_jr:     state_d = JR;
          op_addi:          state_d = ADDI_EX;
          op_lw || op_sw:   state_d = ADDR;
          op_beq || op_bne: state_d = BR;
          op_j:             state_d = J;
          op_jal:           state_d = JAL;
          default: begin
            state_d = EXC;
            cause_d = 2'd0;
          end
        endcase
      end
      R_EX: begin
        if (ovf_arith) begin
          state_d = EXC;
          cause_d = 2'd1;
        end else begin
          state_d = R_WB;
        end
      end
      ADDI_EX: begin
        if (cu.ALU_overflow) begin
          state_d = EXC;
          cause_d = 2'd1;
        end else begin
          state_d = I_WB;
        end
      end
      ADDR:   state_d = op_lw ? LW_RD : SW_WR;
      LW_RD:  state_d = LW_W;
      LW_W:   state_d = LW_WB;
      EXC:    state_d = EXC_W;
      EXC_W:  state_d = EXC_LD;
      R_WB, I_WB, LW_WB, SW_WR, BR, J, JAL, JR, EXC_LD:
        state_d = FETCH;
      default: state_d = RESET_ST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RESET_ST;
      cause_q <= 2'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    cu.PcWrite     = 1'b0;
    cu.Load_AB     = 1'b0;
    cu.ALUOut_Load = 1'b0;
    cu.EPCwrite    = 1'b0;
    cu.MemWrite    = 1'b0;
    cu.MemRead     = 1'b0;
    cu.IRWrite     = 1'b0;
    cu.RegWrite    = 1'b0;
    cu.ALUOp       = 3'd0;
    cu.IorD        = 3'd0;
    cu.ExCause     = 2'd0;
    cu.WR_REG      = 3'd0;
    cu.WD_REG      = 4'd0;
    cu.ALUSrcA     = 3'd0;
    cu.ALUSrcB     = 3'd0;
    cu.PcSource    = 3'd0;
    cu.SingExCtrl  = 1'b0;
    cu.LoadCtrl    = 2'b00;
    cu.StoreCtrl   = 2'b00;
    // reset low blanks every strobe so nothing half-done can land
    if (reset) begin
      unique case (state_q)
        RESET_ST: begin
          cu.RegWrite = 1'b1;
          cu.WR_REG   = 3'd3;
          cu.WD_REG   = 4'd2;
        end
        FETCH: begin
          cu.MemRead = 1'b1;
          cu.ALUSrcB = 3'd1;
          cu.ALUOp   = 3'b001;
          cu.PcWrite = 1'b1;
        end
        FETCH_W: begin
          cu.MemRead = 1'b1;
          cu.IRWrite = 1'b1;
        end
        DECODE: begin
          cu.Load_AB     = 1'b1;
          cu.ALUSrcB     = 3'd3;
          cu.ALUOp       = 3'b001;
          cu.ALUOut_Load = 1'b1;
        end
        R_EX: begin
          cu.ALUSrcA     = 3'd1;
          cu.ALUOut_Load = 1'b1;
          unique case (1'b1)
            f_sub:   cu.ALUOp = 3'b010;
            f_and:   cu.ALUOp = 3'b011;
            default: cu.ALUOp = 3'b001;
          endcase
        end
        R_WB: begin
          cu.RegWrite = 1'b1;
          cu.WR_REG   = 3'd1;
        end
        ADDI_EX, ADDR: begin
          cu.ALUSrcA     = 3'd1;
          cu.ALUSrcB     = 3'd2;
          cu.ALUOp       = 3'b001;
          cu.ALUOut_Load = 1'b1;
        end
        I_WB: cu.RegWrite = 1'b1;
        LW_RD, LW_W: begin
          cu.MemRead = 1'b1;
          cu.IorD    = 3'd2;
        end
        LW_WB: begin
          cu.RegWrite = 1'b1;
          cu.WD_REG   = 4'd1;
        end
        SW_WR: begin
          cu.MemWrite = 1'b1;
          cu.IorD     = 3'd2;
        end
        BR: begin
          cu.ALUSrcA  = 3'd1;
          cu.ALUOp    = 3'b111;
          cu.PcSource = 3'd1;
          cu.PcWrite  = op_beq ? cu.ALU_eq : !cu.ALU_eq;
        end
        J: begin
          cu.PcSource = 3'd2;
          cu.PcWrite  = 1'b1;
        end
        JAL: begin
          cu.RegWrite = 1'b1;
          cu.WR_REG   = 3'd2;
          cu.WD_REG   = 4'd3;
          cu.PcSource = 3'd2;
          cu.PcWrite  = 1'b1;
        end
        JR: begin
          cu.ALUSrcA = 3'd1;
          cu.PcWrite = 1'b1;
        end
        EXC: begin
          cu.ALUSrcB  = 3'd1;
          cu.ALUOp    = 3'b010;
          cu.EPCwrite = 1'b1;
          cu.IorD     = 3'd1;
          cu.MemRead  = 1'b1;
          cu.ExCause  = cause_q;
        end
        EXC_W: begin
          cu.IorD    = 3'd1;
          cu.MemRead = 1'b1;
          cu.ExCause = cause_q;
        end
        EXC_LD: begin
          cu.PcSource = 3'd4;
          cu.LoadCtrl = 2'b10;
          cu.PcWrite  = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected control schedules
// built from the instruction rules, compared cycle by cycle.
module tb_control_unit;
  typedef struct packed {
    logic       pcw, ldab, aluld, epcw, memw, memr, irw, regw;
    logic [2:0] aluop, iord;
    logic [1:0] exc;
    logic [2:0] wr;
    logic [3:0] wd;
    logic [2:0] srca, srcb, pcs;
    logic       sing;
    logic [1:0] ldc, stc;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;
  ctl_t got;
  ctl_t exp_q[$];

  control_unit_if cu_if ();

  control_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .cu    (cu_if.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    got       = '0;
    got.pcw   = cu_if.PcWrite;
    got.ldab  = cu_if.Load_AB;
    got.aluld = cu_if.ALUOut_Load;
    got.epcw  = cu_if.EPCwrite;
    got.memw  = cu_if.MemWrite;
    got.memr  = cu_if.MemRead;
    got.irw   = cu_if.IRWrite;
    got.regw  = cu_if.RegWrite;
    got.aluop = cu_if.ALUOp;
    got.iord  = cu_if.IorD;
    got.exc   = cu_if.ExCause;
    got.wr    = cu_if.WR_REG;
    got.wd    = cu_if.WD_REG;
    got.srca  = cu_if.ALUSrcA;
    got.srcb  = cu_if.ALUSrcB;
    got.pcs   = cu_if.PcSource;
    got.sing  = cu_if.SingExCtrl;
    got.ldc   = cu_if.LoadCtrl;
    got.stc   = cu_if.StoreCtrl;
  end

  task automatic chk(input string tag, input ctl_t e);
    n_chk++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, e);
    end
  endtask

  function automatic ctl_t w_reset();
    ctl_t c = '0;
    c.regw = 1; c.wr = 3; c.wd = 2;
    return c;
  endfunction

  // Exception entry: EPC <= PC-4, read vector byte, load PC
  task automatic push_exc(input logic [1:0] cause);
    ctl_t c;
    c = '0; c.srcb = 1; c.aluop = 3'b010; c.epcw = 1;
    c.iord = 1; c.memr = 1; c.exc = cause;
    exp_q.push_back(c);
    c = '0; c.iord = 1; c.memr = 1; c.exc = cause;
    exp_q.push_back(c);
    c = '0; c.pcs = 4; c.ldc = 2'b10; c.pcw = 1;
    exp_q.push_back(c);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn,
                       input logic ovf, input logic eq);
    ctl_t c;
    exp_q.delete();
    c = '0; c.memr = 1; c.srcb = 1; c.aluop = 1; c.pcw = 1;
    exp_q.push_back(c);
    c = '0; c.memr = 1; c.irw = 1;
    exp_q.push_back(c);
    c = '0; c.ldab = 1; c.srcb = 3; c.aluop = 1; c.aluld = 1;
    exp_q.push_back(c);
    if (op == 0 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      c = '0; c.srca = 1; c.aluld = 1;
      c.aluop = (fn == 6'h20) ? 3'd1 : (fn == 6'h22) ? 3'd2 : 3'd3;
      exp_q.push_back(c);
      if (fn != 6'h24 && ovf) push_exc(1);
      else begin
        c = '0; c.regw = 1; c.wr = 1; c.wd = 0;
        exp_q.push_back(c);
      end
    end else if (op == 0 && fn == 6'h08) begin
      c = '0; c.srca = 1; c.pcw = 1;
      exp_q.push_back(c);
    end else if (op == 6'h08) begin
      c = '0; c.srca = 1; c.srcb = 2; c.aluop = 1; c.aluld = 1;
      exp_q.push_back(c);
      if (ovf) push_exc(1);
      else begin
        c = '0; c.regw = 1;
        exp_q.push_back(c);
      end
    end else if (op == 6'h23 || op == 6'h2B) begin
      c = '0; c.srca = 1; c.srcb = 2; c.aluop = 1; c.aluld = 1;
      exp_q.push_back(c);
      if (op == 6'h23) begin
        c = '0; c.memr = 1; c.iord = 2;
        exp_q.push_back(c);
        exp_q.push_back(c);
        c = '0; c.regw = 1; c.wd = 1;
        exp_q.push_back(c);
      end else begin
        c = '0; c.memw = 1; c.iord = 2;
        exp_q.push_back(c);
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      c = '0; c.srca = 1; c.aluop = 3'b111; c.pcs = 1;
      c.pcw = (op == 6'h04) ? eq : !eq;
      exp_q.push_back(c);
    end else if (op == 6'h02) begin
      c = '0; c.pcs = 2; c.pcw = 1;
      exp_q.push_back(c);
    end else if (op == 6'h03) begin
      c = '0; c.regw = 1; c.wr = 2; c.wd = 3; c.pcs = 2; c.pcw = 1;
      exp_q.push_back(c);
    end else begin
      push_exc(0);
    end
  endtask

  // Entered just after a FETCH edge; leaves just after the next one
  task automatic run(input string tag, input logic [5:0] op,
                     input logic [5:0] fn, input logic ovf,
                     input logic eq);
    cu_if.OP = op;
    cu_if.Funct = fn;
    cu_if.ALU_overflow = ovf;
    cu_if.ALU_eq = eq;
    build(op, fn, ovf, eq);
    foreach (exp_q[i]) begin
      @(negedge clk);
      chk($sformatf("%s_s%0d", tag, i), exp_q[i]);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    ctl_t zero;
    logic [5:0] ops[11];
    logic [5:0] fns[5];
    zero = '0;
    reset = 1'b0;
    cu_if.OP = 6'h00;
    cu_if.Funct = 6'h00;
    cu_if.ALU_overflow = 1'b0;
    cu_if.ALU_eq = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_hold%0d", i), zero);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_st", w_reset());
    @(posedge clk);
    #1;

    run("lw", 6'h23, 6'h11, 1'b0, 1'b0);
    run("beq_t", 6'h04, 6'h00, 1'b0, 1'b1);
    run("beq_n", 6'h04, 6'h00, 1'b0, 1'b0);
    run("bne_t", 6'h05, 6'h00, 1'b0, 1'b0);
    run("bne_n", 6'h05, 6'h00, 1'b0, 1'b1);
    run("add_ovf", 6'h00, 6'h20, 1'b1, 1'b0);
    run("and_ovf", 6'h00, 6'h24, 1'b1, 1'b0);
    run("addi_ovf", 6'h08, 6'h00, 1'b1, 1'b0);
    run("bad_op", 6'h3F, 6'h00, 1'b0, 1'b0);
    run("sw", 6'h2B, 6'h00, 1'b0, 1'b0);
    run("jal", 6'h03, 6'h00, 1'b0, 1'b0);
    run("jr", 6'h00, 6'h08, 1'b0, 1'b0);

    // lw aborted by reset sampled at the end of LW_W
    cu_if.OP = 6'h23;
    cu_if.ALU_overflow = 1'b0;
    build(6'h23, 6'h00, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("abort_s%0d", i), exp_q[i]);
      if (i < 5) begin
        @(posedge clk);
        #1;
      end
    end
    #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_zero", zero);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("abort_rst_st", w_reset());
    @(posedge clk);
    #1;
    run("post_abort_add", 6'h00, 6'h22, 1'b0, 1'b0);

    ops = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B,
            6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h00};
    for (int k = 0; k < 60; k++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 10)];
      if (op == 6'h3F) op = 6'($urandom_range(0, 63));
      fn = fns[$urandom_range(0, 4)];
      if (fn == 6'h00) fn = 6'($urandom_range(0, 63));
      run($sformatf("rnd%0d", k), op, fn,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
